// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB)
// Optional cycle/instruction counters are built when MC_CTRL_PERF_CNT_EN is defined.
module mc_ctrl_fsm #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_incr,
  output logic        pc_jump,
  output logic        pc_branch,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        mem_write,
  output logic        halted,
  output logic [1:0]  err_code
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ins_cnt
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int WAIT_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

  logic [2:0]        state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        err_q, err_d;
  logic [2:0]        boundary_state;
  logic [WAIT_W-1:0] wait_sat;
  logic              op_legal;

  always_comb begin
    op_legal = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
               (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);
  end

  // run only matters where one instruction ends and the next would begin
  assign boundary_state = run ? S_FETCH : S_IDLE;
  assign wait_sat       = (&wait_q) ? wait_q : wait_q + WAIT_W'(1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        if (op_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_R, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:  state_d = S_MEM;
          default:       state_d = boundary_state;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          wait_d  = '0;
          state_d = (op_q == OP_LW) ? S_WB : boundary_state;
        end else begin
          wait_d = wait_sat;
          if ((MEM_WAIT_MAX != 0) && (wait_sat == WAIT_LIMIT)) begin
            state_d = S_HALT;
            err_d   = ERR_TIMEOUT;
          end
        end
      end
      S_WB:     state_d = boundary_state;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    ir_write   = 1'b0;
    pc_incr    = 1'b0;
    pc_jump    = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    mem_write  = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_incr  = 1'b1;
      end
      S_EXEC: begin
        case (op_q)
          OP_R:                 alu_op = 2'b10;
          OP_LW, OP_SW, OP_ADDI: alu_src_b = 1'b1;
          OP_BEQ:               alu_op = 2'b01;
          OP_J:                 pc_jump = 1'b1;
          default:              alu_op = 2'b00;
        endcase
      end
      S_MEM: begin
        alu_src_b = 1'b1;
        mem_write = (op_q == OP_SW);
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_R);
        mem_to_reg = (op_q == OP_LW);
      end
      S_HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

  assign pc_branch = (state_q == S_EXEC) && (op_q == OP_BEQ) && zero;
  assign err_code  = err_q;

`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] cyc_q, cyc_d, ins_q, ins_d;
  logic        ins_done;

  // An instruction completes when its final state hands over to FETCH/IDLE
  always_comb begin
    ins_done = ((state_q == S_EXEC) && ((op_q == OP_BEQ) || (op_q == OP_J))) ||
               ((state_q == S_MEM) && mem_ready && (op_q == OP_SW)) ||
               (state_q == S_WB);
    cyc_d = cyc_q;
    ins_d = ins_q;
    if ((state_q != S_IDLE) && (state_q != S_HALT)) cyc_d = cyc_q + 32'd1;
    if (ins_done) ins_d = ins_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ins_cnt = ins_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - randomized self-checking bench for mc_ctrl_fsm
// Expected per-cycle outputs come from a per-instruction rule table expanded into a cycle queue.
module tb_mc_ctrl_fsm;
  localparam int MAXW = 15;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // Output vector bit weights: {ir,pci,pcj,pcb,rw,rd,m2r,asb,aop[1:0],mw,halt,err[1:0]}
  localparam logic [13:0] IRW = 14'h2000, PCI = 14'h1000, PCJ = 14'h0800, PCB = 14'h0400;
  localparam logic [13:0] RW  = 14'h0200, RD  = 14'h0100, M2R = 14'h0080, ASB = 14'h0040;
  localparam logic [13:0] AFN = 14'h0020, ASUB = 14'h0010, MW = 14'h0008, HLT = 14'h0004;
  localparam logic [13:0] E_ILL = 14'h0001, E_TO = 14'h0002;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, zero, mem_ready;
  logic [5:0]  opcode;
  logic        ir_write, pc_incr, pc_jump, pc_branch, reg_write, reg_dst;
  logic        mem_to_reg, alu_src_b, mem_write, halted;
  logic [1:0]  alu_op, err_code;
`ifdef MC_CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt, ins_cnt;
`endif

  mc_ctrl_fsm #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_incr(pc_incr),
    .pc_jump(pc_jump), .pc_branch(pc_branch), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .mem_write(mem_write), .halted(halted), .err_code(err_code)
`ifdef MC_CTRL_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ins_cnt(ins_cnt)
`endif
  );

  logic [13:0] dut_vec;
  assign dut_vec = {ir_write, pc_incr, pc_jump, pc_branch, reg_write, reg_dst,
                    mem_to_reg, alu_src_b, alu_op, mem_write, halted, err_code};

  typedef struct {
    logic        rst_n;
    logic        run;
    logic        mr;
    logic        z;
    logic [5:0]  opc;
    logic [13:0] exp;
    logic        active;
    logic        last;
    logic [31:0] cyc;
    logic [31:0] ins;
  } cyc_t;

  cyc_t tmp[$];
  cyc_t q[$];
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] g_cyc = 0;
  logic [31:0] g_ins = 0;
  logic [5:0] legal_ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic rb();
    return $urandom_range(0, 1) != 0;
  endfunction

  function automatic logic [5:0] ro();
    return 6'($urandom);
  endfunction

  function automatic logic is_legal(input logic [5:0] o);
    foreach (legal_ops[i]) if (legal_ops[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add(input logic run_v, input logic mr, input logic z, input logic [5:0] opc,
                     input logic [13:0] e, input logic act, input logic lst);
    cyc_t r;
    r.rst_n = 1'b1; r.run = run_v; r.mr = mr; r.z = z; r.opc = opc; r.exp = e;
    r.active = act; r.last = lst; r.cyc = 0; r.ins = 0;
    tmp.push_back(r);
  endtask

  task automatic stamp(input cyc_t r);
    cyc_t s;
    s = r;
    s.cyc = g_cyc;
    s.ins = g_ins;
    q.push_back(s);
    if (r.active) g_cyc++;
    if (r.last) g_ins++;
  endtask

  task automatic idle_rec(input logic run_v);
    cyc_t r;
    r.rst_n = 1'b1; r.run = run_v; r.mr = rb(); r.z = rb(); r.opc = ro(); r.exp = '0;
    r.active = 1'b0; r.last = 1'b0; r.cyc = 0; r.ins = 0;
    stamp(r);
  endtask

  task automatic do_reset();
    cyc_t r;
    r.rst_n = 1'b0; r.run = rb(); r.mr = rb(); r.z = rb(); r.opc = ro(); r.exp = '0;
    r.active = 1'b0; r.last = 1'b0; r.cyc = 0; r.ins = 0;
    g_cyc = 0;
    g_ins = 0;
    stamp(r);
    idle_rec(1'b1);
  endtask

  // Expand one instruction into its expected cycles; nwait = MEM cycles with mem_ready low
  task automatic gen_instr(input logic [5:0] opc, input logic z, input int nwait,
                           input logic run_after, output logic to_halt, output logic [13:0] herr);
    logic [13:0] mv;
    tmp.delete();
    to_halt = 1'b0;
    herr = '0;
    add(rb(), rb(), rb(), ro(), IRW | PCI, 1'b1, 1'b0);
    add(rb(), rb(), rb(), opc, '0, 1'b1, 1'b0);
    case (opc)
      OP_R: begin
        add(rb(), rb(), rb(), ro(), AFN, 1'b1, 1'b0);
        add(run_after, rb(), rb(), ro(), RW | RD, 1'b1, 1'b1);
      end
      OP_ADDI: begin
        add(rb(), rb(), rb(), ro(), ASB, 1'b1, 1'b0);
        add(run_after, rb(), rb(), ro(), RW, 1'b1, 1'b1);
      end
      OP_BEQ: add(run_after, rb(), z, ro(), ASUB | (z ? PCB : 14'h0), 1'b1, 1'b1);
      OP_J:   add(run_after, rb(), rb(), ro(), PCJ, 1'b1, 1'b1);
      OP_LW, OP_SW: begin
        mv = ASB | ((opc == OP_SW) ? MW : 14'h0);
        add(rb(), rb(), rb(), ro(), ASB, 1'b1, 1'b0);
        for (int w = 0; w <= nwait; w++) begin
          if (w < nwait) begin
            add(rb(), 1'b0, rb(), ro(), mv, 1'b1, 1'b0);
            if (MAXW > 0 && w + 1 == MAXW) begin
              to_halt = 1'b1;
              herr = E_TO;
              break;
            end
          end else begin
            add((opc == OP_SW) ? run_after : rb(), 1'b1, rb(), ro(), mv, 1'b1, opc == OP_SW);
          end
        end
        if (opc == OP_LW && !to_halt) add(run_after, rb(), rb(), ro(), RW | M2R, 1'b1, 1'b1);
      end
      default: begin
        to_halt = 1'b1;
        herr = E_ILL;
      end
    endcase
  endtask

  // keep < 0: whole instruction; otherwise reset replaces cycle index keep
  task automatic commit(input int keep, input logic to_halt, input logic [13:0] herr,
                        input logic run_after);
    int n;
    n = (keep < 0 || keep >= tmp.size()) ? tmp.size() : keep;
    for (int i = 0; i < n; i++) stamp(tmp[i]);
    if (keep >= 0 && keep < tmp.size()) begin
      do_reset();
    end else if (to_halt) begin
      for (int i = 0; i < 3; i++) begin
        add(rb(), rb(), rb(), ro(), HLT | herr, 1'b0, 1'b0);
        stamp(tmp[tmp.size()-1]);
      end
      do_reset();
    end else if (!run_after) begin
      if (rb()) idle_rec(1'b0);
      idle_rec(1'b1);
    end
  endtask

  initial begin
    logic th;
    logic [13:0] he;
    logic [5:0] opc;
    logic z, ra;
    int nw, keep, cnt;

    reset = 1'b0; run = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;

    do_reset();
    gen_instr(OP_R, 1'b0, 0, 1'b1, th, he);
    chk("model_r_len", tmp.size(), 4);
    chk("model_r_fetch", 32'(tmp[0].exp), 32'h3000);
    chk("model_r_wb", 32'(tmp[3].exp), 32'h0300);
    commit(-1, th, he, 1'b1);
    gen_instr(OP_J, 1'b0, 0, 1'b0, th, he);
    commit(-1, th, he, 1'b0);
    chk("model_perf_cyc", g_cyc, 7);
    chk("model_perf_ins", g_ins, 2);

    gen_instr(OP_LW, 1'b0, 3, 1'b1, th, he);
    chk("model_lw_len", tmp.size(), 8);
    chk("model_lw_wb", 32'(tmp[7].exp), 32'h0280);
    commit(-1, th, he, 1'b1);
    gen_instr(OP_BEQ, 1'b1, 0, 1'b1, th, he);
    chk("model_beq_len", tmp.size(), 3);
    chk("model_beq_taken", 32'(tmp[2].exp), 32'h0410);
    commit(-1, th, he, 1'b1);
    gen_instr(OP_BEQ, 1'b0, 0, 1'b1, th, he);
    commit(-1, th, he, 1'b1);
    gen_instr(OP_ADDI, 1'b0, 0, 1'b1, th, he);
    commit(-1, th, he, 1'b1);
    gen_instr(OP_SW, 1'b0, 14, 1'b1, th, he);
    commit(-1, th, he, 1'b1);
    gen_instr(OP_LW, 1'b0, 6, 1'b1, th, he);
    commit(5, th, he, 1'b1);
    gen_instr(6'b111111, 1'b0, 0, 1'b1, th, he);
    commit(-1, th, he, 1'b1);
    gen_instr(OP_SW, 1'b0, 20, 1'b1, th, he);
    cnt = 0;
    foreach (tmp[i]) if (tmp[i].exp[3]) cnt++;
    chk("model_sw_timeout_writes", cnt, 15);
    commit(-1, th, he, 1'b1);

    for (int k = 0; k < 150; k++) begin
      opc = legal_ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 19) == 0) begin
        opc = ro();
        while (is_legal(opc)) opc = ro();
      end
      nw = ($urandom_range(0, 9) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 3);
      z = rb();
      ra = ($urandom_range(0, 3) != 0);
      gen_instr(opc, z, nw, ra, th, he);
      keep = ($urandom_range(0, 14) == 0) ? $urandom_range(0, tmp.size() - 1) : -1;
      commit(keep, th, he, ra);
    end

    foreach (q[i]) begin
      @(posedge clk);
      #1;
      reset = q[i].rst_n;
      run = q[i].run;
      mem_ready = q[i].mr;
      zero = q[i].z;
      opcode = q[i].opc;
      #1;
      chk($sformatf("cyc%0d outputs", i), 32'(dut_vec), 32'(q[i].exp));
`ifdef MC_CTRL_PERF_CNT_EN
      chk($sformatf("cyc%0d cyc_cnt", i), cyc_cnt, q[i].cyc);
      chk($sformatf("cyc%0d ins_cnt", i), ins_cnt, q[i].ins);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
